// File: rtl/traffic_monitor.sv
// Receive-side checker for the red/amber/green lamp bus: tracks the
// R -> R+A -> G -> A -> R sequence, latches the first fault and counts cycles.
module traffic_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] seq_count,
  output logic [1:0]       dbg_state
);

  localparam int DW = $clog2(MAX_DWELL + 2);
  localparam logic [DW-1:0] MIN_D = DW'(MIN_DWELL);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);

  localparam logic [1:0] CODE_ILLEGAL = 2'd0;
  localparam logic [1:0] CODE_BADTRAN = 2'd1;
  localparam logic [1:0] CODE_STALL   = 2'd2;
  localparam logic [1:0] CODE_SHORT   = 2'd3;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] seq_q, seq_d;

  logic [2:0]    p;
  logic          p_legal;
  logic [1:0]    p_code;
  logic [1:0]    succ;
  logic [DW-1:0] dwell_inc;

  assign p         = {red, amber, green};
  assign succ      = phase_q + 2'd1;
  assign dwell_inc = dwell_q + DW'(1);

  always_comb begin
    p_legal = 1'b1;
    p_code  = 2'd0;
    case (p)
      3'b100:  p_code = 2'd0;
      3'b110:  p_code = 2'd1;
      3'b001:  p_code = 2'd2;
      3'b010:  p_code = 2'd3;
      default: p_legal = 1'b0;
    endcase
  end

  // err_code is only written on the TRACK->FAULT edge, so it keeps the first fault.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    code_d  = code_q;
    seq_d   = seq_q;
    case (state_q)
      SYNC: begin
        if (p_legal) begin
          state_d = TRACK;
          phase_d = p_code;
          dwell_d = DW'(1);
        end
      end
      TRACK: begin
        if (!p_legal) begin
          state_d = FAULT;
          code_d  = CODE_ILLEGAL;
        end else if (p_code == phase_q) begin
          dwell_d = dwell_inc;
          if (dwell_inc > MAX_D) begin
            state_d = FAULT;
            code_d  = CODE_STALL;
          end
        end else if (p_code == succ) begin
          if (dwell_q < MIN_D) begin
            state_d = FAULT;
            code_d  = CODE_SHORT;
          end else begin
            phase_d = succ;
            dwell_d = DW'(1);
            if (succ == 2'd0) seq_d = seq_q + CNT_W'(1);
          end
        end else begin
          state_d = FAULT;
          code_d  = CODE_BADTRAN;
        end
      end
      FAULT: begin
        // The lamp sample on the clearing edge is deliberately ignored.
        if (err_clr) begin
          state_d = SYNC;
          code_d  = 2'd0;
          dwell_d = '0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      phase_q <= 2'd0;
      dwell_q <= '0;
      code_q  <= 2'd0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      code_q  <= code_d;
      seq_q   <= seq_d;
    end
  end

  assign phase     = phase_q;
  assign locked    = (state_q == TRACK);
  assign err       = (state_q == FAULT);
  assign err_code  = code_q;
  assign seq_count = seq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Bench for traffic_monitor: three parameterisations share one lamp bus and
// are compared every cycle against a sequence-rule reference model.
module tb_traffic_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic red = 1'b0, amber = 1'b0, green = 1'b0, err_clr = 1'b0;

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] o_phase[3];
  logic       o_locked[3];
  logic       o_err[3];
  logic [1:0] o_code[3];
  logic [7:0] o_seq[3];
  logic [1:0] dbg[3];
  logic [7:0] sc0, sc1;
  logic [1:0] sc2;

  traffic_monitor #(.MIN_DWELL(1), .MAX_DWELL(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green), .err_clr(err_clr),
    .phase(o_phase[0]), .locked(o_locked[0]), .err(o_err[0]), .err_code(o_code[0]),
    .seq_count(sc0), .dbg_state(dbg[0]));
  traffic_monitor #(.MIN_DWELL(2), .MAX_DWELL(4), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green), .err_clr(err_clr),
    .phase(o_phase[1]), .locked(o_locked[1]), .err(o_err[1]), .err_code(o_code[1]),
    .seq_count(sc1), .dbg_state(dbg[1]));
  traffic_monitor #(.MIN_DWELL(1), .MAX_DWELL(4), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green), .err_clr(err_clr),
    .phase(o_phase[2]), .locked(o_locked[2]), .err(o_err[2]), .err_code(o_code[2]),
    .seq_count(sc2), .dbg_state(dbg[2]));

  assign o_seq[0] = sc0;
  assign o_seq[1] = sc1;
  assign o_seq[2] = {6'd0, sc2};

  // Reference model: one record per instance, driven by the phase rules only.
  int p_min[3]  = '{1, 2, 1};
  int p_max[3]  = '{4, 4, 4};
  int p_mod[3]  = '{256, 256, 4};
  int m_mode[3];   // 0 searching, 1 following the sequence, 2 faulted
  int m_ph[3];
  int m_held[3];
  int m_code[3];
  int m_seq[3];

  localparam logic [2:0] L_R  = 3'b100;
  localparam logic [2:0] L_RA = 3'b110;
  localparam logic [2:0] L_G  = 3'b001;
  localparam logic [2:0] L_A  = 3'b010;

  function automatic int lamp_index(input logic [2:0] p);
    if (p == L_R)  return 0;
    if (p == L_RA) return 1;
    if (p == L_G)  return 2;
    if (p == L_A)  return 3;
    return -1;
  endfunction

  function automatic logic [2:0] lamp_of(input int idx);
    logic [2:0] tbl[4];
    tbl = '{L_R, L_RA, L_G, L_A};
    return tbl[idx % 4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_ph[i] = 0; m_held[i] = 0; m_code[i] = 0; m_seq[i] = 0;
    end
  endtask

  task automatic model_fault(input int i, input int code);
    m_mode[i] = 2;
    m_code[i] = code;
  endtask

  task automatic model_step(input logic [2:0] p, input logic clr);
    int c;
    c = lamp_index(p);
    for (int i = 0; i < 3; i++) begin
      if (m_mode[i] == 0) begin
        if (c >= 0) begin m_mode[i] = 1; m_ph[i] = c; m_held[i] = 1; end
      end else if (m_mode[i] == 1) begin
        if (c < 0) model_fault(i, 0);
        else if (c == m_ph[i]) begin
          m_held[i]++;
          if (m_held[i] > p_max[i]) model_fault(i, 2);
        end else if (c == (m_ph[i] + 1) % 4) begin
          if (m_held[i] < p_min[i]) model_fault(i, 3);
          else begin
            m_ph[i] = c;
            m_held[i] = 1;
            if (c == 0) m_seq[i] = (m_seq[i] + 1) % p_mod[i];
          end
        end else model_fault(i, 1);
      end else if (clr) begin
        m_mode[i] = 0;
        m_code[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".phase"}, i, 32'(o_phase[i]), 32'(m_ph[i]));
      chk({tag, ".locked"}, i, 32'(o_locked[i]), 32'(m_mode[i] == 1));
      chk({tag, ".err"}, i, 32'(o_err[i]), 32'(m_mode[i] == 2));
      chk({tag, ".err_code"}, i, 32'(o_code[i]), 32'(m_code[i]));
      chk({tag, ".seq_count"}, i, 32'(o_seq[i]), 32'(m_seq[i]));
    end
  endtask

  task automatic step(input logic [2:0] p, input logic clr, input string tag);
    @(negedge clk);
    {red, amber, green} = p;
    err_clr = clr;
    @(posedge clk);
    model_step(p, clr);
    #1;
    check_all(tag);
  endtask

  // Reset is applied away from the edge so its asynchronous effect is visible at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    {red, amber, green} = 3'b000;
    err_clr = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic full_seq(input int hold, input string tag);
    for (int ph = 1; ph <= 4; ph++)
      for (int k = 0; k < hold; k++) step(lamp_of(ph), 1'b0, tag);
  endtask

  initial begin
    int gph, left, r;
    logic [2:0] p;
    model_reset();

    // Clean single-cycle sequence.
    do_reset("rst0");
    step(L_R, 1'b0, "t1"); chk("t1_locked", 0, 32'(o_locked[0]), 32'd1);
    step(L_RA, 1'b0, "t1");
    step(L_G, 1'b0, "t1");
    step(L_A, 1'b0, "t1"); chk("t1_phaseA", 0, 32'(o_phase[0]), 32'd3);
    step(L_R, 1'b0, "t1");
    chk("t1_seq", 0, 32'(o_seq[0]), 32'd1);
    chk("t1_err", 0, 32'(o_err[0]), 32'd0);

    // Skip from R straight to G.
    step(L_G, 1'b0, "t2");
    chk("t2_code", 0, 32'(o_code[0]), 32'd1);
    chk("t2_phase", 0, 32'(o_phase[0]), 32'd0);
    chk("t2_locked", 0, 32'(o_locked[0]), 32'd0);

    // Clear: sample ignored, sequence count kept, relock later.
    step(L_R, 1'b1, "t6clr");
    chk("t6_err", 0, 32'(o_err[0]), 32'd0);
    chk("t6_seq", 0, 32'(o_seq[0]), 32'd1);
    chk("t6_nolock", 0, 32'(o_locked[0]), 32'd0);
    step(L_R, 1'b0, "t6relock");

    // Illegal pattern, then a second fault that must not overwrite the first.
    step(3'b111, 1'b0, "t3");
    chk("t3_code", 0, 32'(o_code[0]), 32'd0);
    chk("t3_err", 0, 32'(o_err[0]), 32'd1);
    step(3'b000, 1'b0, "t3b");
    chk("t3_held", 0, 32'(o_code[0]), 32'd0);
    step(L_R, 1'b1, "t3clr");

    // Stall: green held for five edges.
    step(L_R, 1'b0, "t4"); step(L_RA, 1'b0, "t4");
    for (int k = 0; k < 4; k++) step(L_G, 1'b0, "t4");
    chk("t4_ok4", 0, 32'(o_err[0]), 32'd0);
    step(L_G, 1'b0, "t4");
    chk("t4_code", 0, 32'(o_code[0]), 32'd2);
    step(L_R, 1'b1, "t4clr");
    step(L_R, 1'b0, "t4b"); step(L_RA, 1'b0, "t4b");
    for (int k = 0; k < 4; k++) step(L_G, 1'b0, "t4b");
    step(L_A, 1'b0, "t4b");
    chk("t4b_err", 0, 32'(o_err[0]), 32'd0);
    chk("t4b_phase", 0, 32'(o_phase[0]), 32'd3);

    // Minimum dwell on the MIN_DWELL=2 instance.
    do_reset("rst5");
    step(L_R, 1'b0, "t5"); step(L_RA, 1'b0, "t5");
    chk("t5_code", 1, 32'(o_code[1]), 32'd3);
    chk("t5_err", 1, 32'(o_err[1]), 32'd1);
    do_reset("rst5b");
    step(L_R, 1'b0, "t5b"); step(L_R, 1'b0, "t5b"); step(L_RA, 1'b0, "t5b");
    chk("t5b_phase", 1, 32'(o_phase[1]), 32'd1);
    chk("t5b_err", 1, 32'(o_err[1]), 32'd0);

    // Reset mid-sequence, then counter wrap on the 2-bit instance.
    step(L_RA, 1'b0, "t6a"); step(L_G, 1'b0, "t6a");
    do_reset("rst_mid");
    step(L_R, 1'b0, "t6w"); step(L_R, 1'b0, "t6w");
    for (int s = 0; s < 4; s++) full_seq(2, "t6w");
    chk("t6_wrap", 2, 32'(o_seq[2]), 32'd0);
    chk("t6_wrap_err", 2, 32'(o_err[2]), 32'd0);
    chk("t6_seq4", 0, 32'(o_seq[0]), 32'd4);

    // Randomised traffic: mostly legal sequences with varied hold times and faults.
    gph = 0;
    left = $urandom_range(1, 5);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) p = 3'($urandom_range(0, 7));
      else if (r < 7) p = lamp_of(gph + 2);
      else begin
        p = lamp_of(gph);
        left--;
        if (left == 0) begin
          gph = (gph + 1) % 4;
          left = $urandom_range(1, 5);
        end
      end
      if (r == 99) do_reset("rnd_rst");
      else step(p, ($urandom_range(0, 7) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
